// File: rtl/string_accel_pkg.sv
// Shared types, CTRL field positions and character-class helpers for string_accel_avalon.
package string_accel_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        OP_CMP    = 3'd0,
        OP_UPPER  = 3'd1,
        OP_LOWER  = 3'd2,
        OP_STRLEN = 3'd3,
        OP_TOGGLE = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int unsigned CTRL_DONE    = 0;
    localparam int unsigned CTRL_GO      = 1;
    localparam int unsigned CTRL_OP_LSB  = 2;
    localparam int unsigned CTRL_OP_MSB  = 4;
    localparam int unsigned CTRL_IRQ_EN  = 5;
    localparam int unsigned CTRL_ERR     = 6;
    localparam int unsigned CTRL_LEN_LSB = 8;
    localparam int unsigned CTRL_LEN_MSB = 15;

    function automatic logic is_lower(byte_t b);
        return (b >= 8'h61) && (b <= 8'h7a);
    endfunction

    function automatic logic is_upper(byte_t b);
        return (b >= 8'h41) && (b <= 8'h5a);
    endfunction

endpackage

// File: rtl/string_accel_avalon_string_byte_alu.sv
// Combinational per-byte operation: case conversion, equality and NUL detection.
module string_byte_alu
    import string_accel_pkg::*;
(
    input  byte_t      i_a,
    input  byte_t      i_b,
    input  logic [2:0] i_op,
    output byte_t      o_r,
    output logic       o_mismatch,
    output logic       o_is_nul
);

    always_comb begin
        o_r = i_a;
        case (i_op)
            OP_UPPER:  if (is_lower(i_a)) o_r = i_a ^ 8'h20;
            OP_LOWER:  if (is_upper(i_a)) o_r = i_a ^ 8'h20;
            OP_TOGGLE: if (is_lower(i_a) || is_upper(i_a)) o_r = i_a ^ 8'h20;
            default:   o_r = i_a;
        endcase
    end

    assign o_mismatch = (i_a != i_b);
    assign o_is_nul   = (i_a == 8'h00);

endmodule

// File: rtl/string_accel_avalon.sv
// Avalon-MM string accelerator: A/B/R byte buffers, CTRL/SCALAR registers, byte-serial FSM.
// Optional level interrupt output o_irq when STRING_ACCEL_IRQ_EN is defined.
module string_accel_avalon
    import string_accel_pkg::*;
#(
    parameter int unsigned  MAX_WORDS = 4,
    localparam int unsigned MAX_BYTES = 4 * MAX_WORDS,
    localparam int unsigned ADDR_W    = $clog2(3 * MAX_WORDS + 2)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_chipselect,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_write,
    input  logic [31:0]       i_writedata,
    input  logic              i_read,
    output logic [31:0]       o_readdata
`ifdef STRING_ACCEL_IRQ_EN
    ,
    output logic              o_irq
`endif
);

    localparam int unsigned BW          = $clog2(MAX_BYTES);
    localparam int unsigned IW          = $clog2(MAX_BYTES + 1);
    localparam int unsigned A_BASE      = 0;
    localparam int unsigned B_BASE      = MAX_WORDS;
    localparam int unsigned CTRL_ADDR   = 2 * MAX_WORDS;
    localparam int unsigned SCALAR_ADDR = 2 * MAX_WORDS + 1;
    localparam int unsigned R_BASE      = 2 * MAX_WORDS + 2;

    state_e      r_state, w_state_d;
    byte_t       r_a [MAX_BYTES];
    byte_t       r_b [MAX_BYTES];
    byte_t       r_r [MAX_BYTES];
    logic [2:0]  r_op;
    logic [7:0]  r_length;
    logic        r_err;
    logic [31:0] r_scalar;
    logic [BW-1:0] r_idx;
    logic [31:0] r_readdata;

    logic [31:0] w_addr;
    logic        w_wr, w_rd, w_ctrl_wr, w_go, w_irq_en;
    logic        w_start, w_step, w_finish, w_err_val;
    logic [31:0] w_scalar_val, w_rdata, w_ctrl;
    logic [IW-1:0] w_nul_idx, w_n;
    logic        w_last, w_case_op, w_reserved;
    byte_t       w_alu_r;
    logic        w_alu_mismatch, w_alu_nul;

`ifdef STRING_ACCEL_IRQ_EN
    logic r_irq_en;
    assign w_irq_en = r_irq_en;
    assign o_irq    = (r_state == DONE) & r_irq_en;
`else
    assign w_irq_en = 1'b0;
`endif

    assign w_addr     = 32'(i_address);
    assign w_wr       = i_chipselect & i_write;
    assign w_rd       = i_chipselect & i_read;
    assign w_ctrl_wr  = w_wr && (w_addr == CTRL_ADDR);
    assign w_go       = i_writedata[CTRL_GO];
    assign w_case_op  = (r_op == OP_UPPER) || (r_op == OP_LOWER) || (r_op == OP_TOGGLE);
    assign w_reserved = (r_op > 3'd4);

    // Effective length: explicit length capped at buffer size, or first NUL in A.
    always_comb begin
        w_nul_idx = IW'(MAX_BYTES);
        for (int k = MAX_BYTES - 1; k >= 0; k--) begin
            if (r_a[k] == 8'h00) w_nul_idx = IW'(k);
        end
    end

    assign w_n    = (r_length == 8'd0) ? w_nul_idx :
                    (32'(r_length) > MAX_BYTES) ? IW'(MAX_BYTES) : IW'(r_length);
    assign w_last = (IW'(r_idx) + IW'(1)) == w_n;

    string_byte_alu u_alu (
        .i_a        (r_a[r_idx]),
        .i_b        (r_b[r_idx]),
        .i_op       (r_op),
        .o_r        (w_alu_r),
        .o_mismatch (w_alu_mismatch),
        .o_is_nul   (w_alu_nul)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_d;
    end

    always_comb begin
        w_state_d    = r_state;
        w_start      = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_err_val    = 1'b0;
        w_scalar_val = '0;
        unique case (r_state)
            IDLE: begin
                if (w_ctrl_wr && w_go) begin
                    w_start   = 1'b1;
                    w_state_d = RUN;
                end
            end
            RUN: begin
                if (w_ctrl_wr && !w_go) begin
                    w_state_d = IDLE;
                end else if (w_reserved) begin
                    w_finish  = 1'b1;
                    w_err_val = 1'b1;
                    w_state_d = DONE;
                end else if (w_n == '0) begin
                    w_finish     = 1'b1;
                    w_scalar_val = (r_op == OP_CMP) ? 32'd1 : 32'd0;
                    w_state_d    = DONE;
                end else begin
                    w_step = 1'b1;
                    if (r_op == OP_CMP && w_alu_mismatch) begin
                        w_finish  = 1'b1;
                        w_state_d = DONE;
                    end else if (r_op == OP_STRLEN && w_alu_nul) begin
                        w_finish     = 1'b1;
                        w_scalar_val = 32'(r_idx);
                        w_state_d    = DONE;
                    end else if (w_last) begin
                        w_finish     = 1'b1;
                        w_scalar_val = (r_op == OP_CMP) ? 32'd1 : 32'(w_n);
                        w_state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (w_ctrl_wr) begin
                    w_start   = w_go;
                    w_state_d = w_go ? RUN : IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned k = 0; k < MAX_BYTES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_r[k] <= '0;
            end
            r_op     <= '0;
            r_length <= '0;
            r_err    <= 1'b0;
            r_scalar <= '0;
            r_idx    <= '0;
`ifdef STRING_ACCEL_IRQ_EN
            r_irq_en <= 1'b0;
`endif
        end else begin
            if (w_wr && r_state != RUN) begin
                for (int unsigned k = 0; k < MAX_WORDS; k++) begin
                    for (int unsigned j = 0; j < 4; j++) begin
                        if (w_addr == A_BASE + k) r_a[4*k+j] <= i_writedata[31-8*j -: 8];
                        if (w_addr == B_BASE + k) r_b[4*k+j] <= i_writedata[31-8*j -: 8];
                    end
                end
            end
            if (w_start) begin
                r_op     <= i_writedata[CTRL_OP_MSB:CTRL_OP_LSB];
                r_length <= i_writedata[CTRL_LEN_MSB:CTRL_LEN_LSB];
                r_err    <= 1'b0;
                r_scalar <= '0;
                r_idx    <= '0;
                for (int unsigned k = 0; k < MAX_BYTES; k++) r_r[k] <= '0;
`ifdef STRING_ACCEL_IRQ_EN
                r_irq_en <= i_writedata[CTRL_IRQ_EN];
`endif
            end
            if (w_step) begin
                r_idx <= r_idx + BW'(1);
                if (w_case_op) r_r[r_idx] <= w_alu_r;
            end
            if (w_finish) begin
                r_scalar <= w_scalar_val;
                r_err    <= w_err_val;
            end
        end
    end

    always_comb begin
        w_ctrl                              = '0;
        w_ctrl[CTRL_DONE]                   = (r_state == DONE);
        w_ctrl[CTRL_GO]                     = (r_state != IDLE);
        w_ctrl[CTRL_OP_MSB:CTRL_OP_LSB]     = r_op;
        w_ctrl[CTRL_IRQ_EN]                 = w_irq_en;
        w_ctrl[CTRL_ERR]                    = r_err;
        w_ctrl[CTRL_LEN_MSB:CTRL_LEN_LSB]   = r_length;
    end

    always_comb begin
        w_rdata = '0;
        for (int unsigned k = 0; k < MAX_WORDS; k++) begin
            if (w_addr == A_BASE + k) w_rdata = {r_a[4*k], r_a[4*k+1], r_a[4*k+2], r_a[4*k+3]};
            if (w_addr == B_BASE + k) w_rdata = {r_b[4*k], r_b[4*k+1], r_b[4*k+2], r_b[4*k+3]};
            if (w_addr == R_BASE + k) w_rdata = {r_r[4*k], r_r[4*k+1], r_r[4*k+2], r_r[4*k+3]};
        end
        if (w_addr == CTRL_ADDR)   w_rdata = w_ctrl;
        if (w_addr == SCALAR_ADDR) w_rdata = r_scalar;
    end

    // Read data comes from current state, so a same-cycle write is not visible yet.
    always_ff @(posedge i_clk) begin
        if (i_reset)   r_readdata <= '0;
        else if (w_rd) r_readdata <= w_rdata;
    end

    assign o_readdata = r_readdata;

endmodule

// File: tb/tb_string_accel_avalon.sv
// Self-checking bench for string_accel_avalon: directed cases plus random ops against a byte model.
module tb_string_accel_avalon;

    localparam int MW   = 4;
    localparam int MB   = 16;
    localparam int AW   = 4;
    localparam int CTRL = 8;
    localparam int SCAL = 9;
    localparam int RB   = 10;

    logic          clk = 1'b0;
    logic          reset, cs, wr, rd;
    logic [AW-1:0] address;
    logic [31:0]   wdata, rdata;
`ifdef STRING_ACCEL_IRQ_EN
    logic          irq;
    localparam bit IEN_EXP = 1'b1;
`else
    localparam bit IEN_EXP = 1'b0;
`endif

    string_accel_avalon dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_chipselect (cs),
        .i_address    (address),
        .i_write      (wr),
        .i_writedata  (wdata),
        .i_read       (rd),
        .o_readdata   (rdata)
`ifdef STRING_ACCEL_IRQ_EN
        ,
        .o_irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  m_a [MB];
    logic [7:0]  m_b [MB];
    logic [7:0]  exp_r [MB];
    int          exp_scalar, exp_cyc;
    bit          exp_err;
    logic [31:0] got_scalar, got_ctrl;
    logic [31:0] got_r [MW];

    // All bus tasks are entered at a negedge and return at a negedge.
    task automatic bus_write(input int addr, input logic [31:0] data);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; address = AW'(addr); wdata = data;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input int addr, output logic [31:0] data);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; address = AW'(addr);
        @(negedge clk);
        data = rdata;
        cs = 1'b0; rd = 1'b0;
    endtask

    // Reads CTRL every cycle; cyc is the cycle index whose state first shows done (0 = timeout).
    task automatic poll_done(input int first, output int cyc);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; address = AW'(CTRL);
        cyc = 0;
        for (int c = first; c < first + 40; c++) begin
            @(negedge clk);
            if (rdata[0] === 1'b1) begin
                cyc = c;
                break;
            end
        end
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic collect();
        bus_read(SCAL, got_scalar);
        bus_read(CTRL, got_ctrl);
        for (int k = 0; k < MW; k++) bus_read(RB + k, got_r[k]);
    endtask

    task automatic load_buffers();
        for (int k = 0; k < MW; k++) begin
            bus_write(k, {m_a[4*k], m_a[4*k+1], m_a[4*k+2], m_a[4*k+3]});
            bus_write(MW + k, {m_b[4*k], m_b[4*k+1], m_b[4*k+2], m_b[4*k+3]});
        end
    endtask

    task automatic set_a(input string s);
        for (int i = 0; i < MB; i++) m_a[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    task automatic set_b(input string s);
        for (int i = 0; i < MB; i++) m_b[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    function automatic logic [31:0] ctrl_word(input int op, input int len, input bit ien,
                                              input bit go);
        return {16'd0, 8'(len), 2'b00, ien, 3'(op), go, 1'b0};
    endfunction

    function automatic logic [7:0] case_fn(input int op, input logic [7:0] c);
        bit lo, up;
        lo = (c >= 8'd97) && (c <= 8'd122);
        up = (c >= 8'd65) && (c <= 8'd90);
        if (op == 1 && lo) return c - 8'd32;
        if (op == 2 && up) return c + 8'd32;
        if (op == 4 && lo) return c - 8'd32;
        if (op == 4 && up) return c + 8'd32;
        return c;
    endfunction

    // Reference: effective length, then per-op result and the cycle at which done is visible.
    task automatic model(input int op, input int len);
        int n, stop;
        n = MB;
        for (int i = MB - 1; i >= 0; i--) if (m_a[i] == 8'h00) n = i;
        if (len != 0) n = (len < MB) ? len : MB;
        for (int i = 0; i < MB; i++) exp_r[i] = 8'h00;
        exp_err = 1'b0;
        stop    = -1;
        case (op)
            0: begin
                exp_scalar = 1;
                for (int i = 0; i < n; i++) if (m_a[i] != m_b[i]) begin
                    exp_scalar = 0; stop = i; break;
                end
            end
            1, 2, 4: begin
                exp_scalar = n;
                for (int i = 0; i < n; i++) exp_r[i] = case_fn(op, m_a[i]);
            end
            3: begin
                exp_scalar = n;
                for (int i = 0; i < n; i++) if (m_a[i] == 8'h00) begin
                    exp_scalar = i; stop = i; break;
                end
            end
            default: begin
                exp_scalar = 0; exp_err = 1'b1; stop = 0;
            end
        endcase
        exp_cyc = (stop >= 0) ? stop + 2 : ((n == 0) ? 2 : n + 1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (rdata !== 32'd0) begin
            n_errors++; $display("FAIL reset_readdata: got=%0h expected=0", rdata);
        end
        for (int a = 0; a < 16; a++) begin
            bus_read(a, d);
            n_checks++;
            if (d !== 32'd0) begin
                n_errors++; $display("FAIL reset_read_%0d: got=%0h expected=0", a, d);
            end
        end
    endtask

    task automatic test_bus_rules();
        logic [31:0] d;
        bus_write(0, 32'h11223344);
        cs = 1'b1; wr = 1'b1; rd = 1'b1; address = AW'(0); wdata = 32'h55667788;
        @(negedge clk);
        d = rdata;
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        n_checks++;
        if (d !== 32'h11223344) begin
            n_errors++; $display("FAIL rw_same_cycle: got=%0h expected=11223344", d);
        end
        bus_read(0, d);
        n_checks++;
        if (d !== 32'h55667788) begin
            n_errors++; $display("FAIL write_then_read: got=%0h expected=55667788", d);
        end
        bus_write(SCAL, 32'hFFFFFFFF);
        bus_write(RB, 32'hFFFFFFFF);
        bus_read(SCAL, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_errors++; $display("FAIL scalar_read_only: got=%0h expected=0", d);
        end
        bus_read(RB, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_errors++; $display("FAIL r_read_only: got=%0h expected=0", d);
        end
        bus_read(15, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_errors++; $display("FAIL unmapped_read: got=%0h expected=0", d);
        end
    endtask

    task automatic test_directed();
        int cyc;
        set_a("abcdefgh"); set_b("abcdefgX"); load_buffers();
        bus_write(CTRL, ctrl_word(0, 8, 1'b0, 1'b1)); poll_done(1, cyc); collect();
        n_checks++;
        if (cyc !== 9) begin n_errors++; $display("FAIL cmp_ne_cycle: got=%0d expected=9", cyc); end
        n_checks++;
        if (got_scalar !== 32'd0) begin
            n_errors++; $display("FAIL cmp_ne_scalar: got=%0d expected=0", got_scalar);
        end
        set_b("abcdefgh"); load_buffers();
        bus_write(CTRL, ctrl_word(0, 8, 1'b0, 1'b1)); poll_done(1, cyc); collect();
        n_checks++;
        if (cyc !== 9) begin n_errors++; $display("FAIL cmp_eq_cycle: got=%0d expected=9", cyc); end
        n_checks++;
        if (got_scalar !== 32'd1) begin
            n_errors++; $display("FAIL cmp_eq_scalar: got=%0d expected=1", got_scalar);
        end
        set_a("Hello, W"); load_buffers();
        bus_write(CTRL, ctrl_word(1, 0, 1'b1, 1'b1)); poll_done(1, cyc); collect();
        n_checks++;
        if (got_scalar !== 32'd8 || cyc !== 9) begin
            n_errors++; $display("FAIL upper_nul_scalar_cycle: got=%0d/%0d expected=8/9", got_scalar, cyc);
        end
        n_checks++;
        if (got_r[0] !== 32'h48454C4C || got_r[1] !== 32'h4F2C2057 || got_r[2] !== 32'd0
            || got_r[3] !== 32'd0) begin
            n_errors++;
            $display("FAIL upper_r_words: got=%h %h %h %h expected=48454c4c 4f2c2057 0 0",
                     got_r[0], got_r[1], got_r[2], got_r[3]);
        end
        n_checks++;
        if (got_ctrl[5] !== IEN_EXP || got_ctrl[1:0] !== 2'b11 || got_ctrl[4:2] !== 3'd1) begin
            n_errors++; $display("FAIL upper_ctrl: got=%0h ien_expected=%0d", got_ctrl, IEN_EXP);
        end
        set_a("aBcD"); load_buffers();
        bus_write(CTRL, ctrl_word(4, 4, 1'b0, 1'b1)); poll_done(1, cyc); collect();
        n_checks++;
        if (got_r[0] !== 32'h41624364) begin
            n_errors++; $display("FAIL toggle_r0: got=%0h expected=41624364", got_r[0]);
        end
        set_a("ABCD"); load_buffers();
        bus_write(CTRL, ctrl_word(2, 4, 1'b0, 1'b1)); poll_done(1, cyc); collect();
        n_checks++;
        if (got_r[0] !== 32'h61626364) begin
            n_errors++; $display("FAIL lower_r0: got=%0h expected=61626364", got_r[0]);
        end
        set_a("ABCDEFGHIJKLMNOP"); load_buffers();
        bus_write(CTRL, ctrl_word(3, 0, 1'b0, 1'b1)); poll_done(1, cyc); collect();
        n_checks++;
        if (got_scalar !== 32'd16 || cyc !== 17) begin
            n_errors++; $display("FAIL strlen_full: got=%0d/%0d expected=16/17", got_scalar, cyc);
        end
        set_a("ab"); load_buffers();
        bus_write(CTRL, ctrl_word(3, 0, 1'b0, 1'b1)); poll_done(1, cyc); collect();
        n_checks++;
        if (got_scalar !== 32'd2) begin
            n_errors++; $display("FAIL strlen_ab: got=%0d expected=2", got_scalar);
        end
        bus_write(CTRL, ctrl_word(6, 5, 1'b0, 1'b1)); poll_done(1, cyc); collect();
        n_checks++;
        if (cyc !== 2 || got_ctrl[6] !== 1'b1 || got_scalar !== 32'd0) begin
            n_errors++;
            $display("FAIL reserved_op: got cyc=%0d err=%0d scalar=%0d expected=2/1/0",
                     cyc, got_ctrl[6], got_scalar);
        end
    endtask

    task automatic test_busy_writes();
        int cyc;
        logic [31:0] d;
        set_a("abcdefghijklmnop"); set_b("abcdefghijklmnop"); load_buffers();
        bus_write(CTRL, ctrl_word(1, 4, 1'b0, 1'b1));
        bus_write(CTRL, ctrl_word(2, 5, 1'b0, 1'b1));
        bus_write(0, 32'hDEADBEEF);
        poll_done(3, cyc);
        collect();
        n_checks++;
        if (cyc !== 5 || got_scalar !== 32'd4 || got_r[0] !== 32'h41424344) begin
            n_errors++;
            $display("FAIL busy_go_ignored: got cyc=%0d scalar=%0d r0=%0h expected=5/4/41424344",
                     cyc, got_scalar, got_r[0]);
        end
        bus_read(0, d);
        n_checks++;
        if (d !== 32'h61626364) begin
            n_errors++; $display("FAIL busy_a_write_ignored: got=%0h expected=61626364", d);
        end
        bus_write(CTRL, ctrl_word(0, 16, 1'b1, 1'b1));
        bus_write(CTRL, ctrl_word(0, 16, 1'b1, 1'b0));
        bus_read(CTRL, d);
        n_checks++;
        if (d[1:0] !== 2'b00) begin
            n_errors++; $display("FAIL abort_ctrl: got done/go=%0b expected=00", d[1:0]);
        end
        repeat (20) @(negedge clk);
        bus_read(CTRL, d);
        n_checks++;
        if (d[1:0] !== 2'b00) begin
            n_errors++; $display("FAIL abort_stays_idle: got done/go=%0b expected=00", d[1:0]);
        end
`ifdef STRING_ACCEL_IRQ_EN
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL abort_irq: got=%0b expected=0", irq); end
`endif
    endtask

    task automatic test_random();
        int op, len, cyc;
        for (int t = 0; t < 40; t++) begin
            op  = $urandom_range(0, 9);
            if (op > 7) op = 0;
            len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
            for (int i = 0; i < MB; i++) begin
                m_a[i] = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(32, 126));
                m_b[i] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(32, 126)) : m_a[i];
            end
            if (t % 3 == 0) bus_write(CTRL, ctrl_word(0, 0, 1'b0, 1'b0));
            load_buffers();
            model(op, len);
            bus_write(CTRL, ctrl_word(op, len, 1'b0, 1'b1));
            poll_done(1, cyc);
            collect();
            n_checks++;
            if (cyc !== exp_cyc || got_scalar !== 32'(exp_scalar) || got_ctrl[6] !== exp_err) begin
                n_errors++;
                $display("FAIL rand_%0d op=%0d len=%0d: got cyc=%0d scalar=%0d err=%0d expected=%0d/%0d/%0d",
                         t, op, len, cyc, got_scalar, got_ctrl[6], exp_cyc, exp_scalar, exp_err);
            end
            if (op == 1 || op == 2 || op == 4) begin
                for (int k = 0; k < MW; k++) begin
                    n_checks++;
                    if (got_r[k] !== {exp_r[4*k], exp_r[4*k+1], exp_r[4*k+2], exp_r[4*k+3]}) begin
                        n_errors++;
                        $display("FAIL rand_%0d_r%0d: got=%0h expected=%0h", t, k, got_r[k],
                                 {exp_r[4*k], exp_r[4*k+1], exp_r[4*k+2], exp_r[4*k+3]});
                    end
                end
            end
        end
    endtask

`ifdef STRING_ACCEL_IRQ_EN
    task automatic test_irq();
        int cyc;
        set_a("abc"); load_buffers();
        bus_write(CTRL, ctrl_word(1, 3, 1'b1, 1'b1));
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_running: got=%0b expected=0", irq); end
        poll_done(1, cyc);
        n_checks++;
        if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_on_done: got=%0b expected=1", irq); end
        bus_write(CTRL, ctrl_word(1, 3, 1'b1, 1'b0));
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_cleared: got=%0b expected=0", irq); end
        bus_write(CTRL, ctrl_word(1, 3, 1'b1, 1'b1));
        poll_done(1, cyc);
    endtask
`endif

    task automatic test_mid_reset();
        logic [31:0] d;
        set_a("abcdefghijklmnop"); set_b("ponmlkjihgfedcba"); load_buffers();
        bus_write(CTRL, ctrl_word(1, 16, 1'b1, 1'b1));
        bus_write(CTRL, ctrl_word(1, 16, 1'b1, 1'b1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (rdata !== 32'd0) begin
            n_errors++; $display("FAIL midreset_readdata: got=%0h expected=0", rdata);
        end
`ifdef STRING_ACCEL_IRQ_EN
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL midreset_irq: got=%0b expected=0", irq); end
`endif
        for (int a = 0; a < 14; a++) begin
            bus_read(a, d);
            n_checks++;
            if (d !== 32'd0) begin
                n_errors++; $display("FAIL midreset_read_%0d: got=%0h expected=0", a, d);
            end
        end
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; address = '0; wdata = '0;
        @(negedge clk);
        test_reset();
        test_bus_rules();
        test_directed();
        test_busy_writes();
        test_random();
`ifdef STRING_ACCEL_IRQ_EN
        test_irq();
`endif
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
